// File: rtl/m_copy_pkg.sv
// Shared definitions for the block-copy sequencer: FSM encoding, widths and the buffered word type.
package m_copy_pkg;

  localparam int unsigned DcW    = 24;
  localparam int unsigned WordsW = 22;
  localparam int unsigned BusW   = 64;
  localparam int unsigned BufD   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic            last;
    logic [BusW-1:0] data;
  } word_t;

endpackage

// File: rtl/m_copy_buf.sv
// Two-entry holding FIFO between source capture and destination push; exposes its occupancy.
module m_copy_buf
  import m_copy_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       wr_i,
  input  word_t      wdata_i,
  input  logic       rd_i,
  output word_t      rdata_o,
  output logic [1:0] occ_o
);

  word_t      mem_q [2];
  logic       wptr_q;
  logic       rptr_q;
  logic [1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else if (flush_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (wr_i) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= ~wptr_q;
      end
      if (rd_i) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, wr_i} - {1'b0, rd_i};
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign occ_o   = cnt_q;

endmodule

// File: rtl/m_copy_seq.sv
// Block-copy sequencer: pops ceil(dc/8) words from the source FIFO and pushes them to the
// destination FIFO through a 2-entry buffer, tagging the final word and reporting done/err.
module m_copy_seq
  import m_copy_pkg::*;
#(
  parameter int unsigned DC_W  = DcW,
  parameter int unsigned BUF_D = BufD
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            start,
  input  logic [DC_W-1:0] dc,
  input  logic            m_reset,
  output logic            m_src_getn,
  input  logic [BusW-1:0] m_src,
  input  logic            m_src_last,
  input  logic            m_src_almost_empty,
  input  logic            m_src_empty,
  output logic            m_dst_putn,
  output logic [BusW-1:0] m_dst,
  output logic            m_dst_last,
  input  logic            m_dst_almost_full,
  input  logic            m_dst_full,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int unsigned CntW   = DC_W - 2;
  localparam logic [2:0]  BufCap = 3'(BUF_D);

  state_e          state_q, state_d;
  logic [CntW-1:0] rd_left_q, rd_left_d;
  logic [CntW-1:0] wr_left_q, wr_left_d;
  logic            pop_q, push_q;
  logic            eol_q, eol_d;
  logic            err_q, err_d;
  logic            done_q, done_d;

  logic            pop, push, cap;
  logic            early_last, miss_last;
  logic [1:0]      occ;
  logic [2:0]      occ_eff, occ_after;
  logic [DC_W:0]   dc_sum;
  logic [CntW-1:0] words;
  word_t           cap_word, head;

  assign dc_sum = {1'b0, dc} + {{(DC_W - 2){1'b0}}, 3'd7};
  assign words  = dc_sum[DC_W:3];

  // Words still in flight after an early last are dropped rather than buffered.
  assign cap        = pop_q & ~eol_q & ~m_reset;
  assign early_last = cap & m_src_last & (rd_left_q != '0);
  assign miss_last  = cap & ~m_src_last & (rd_left_q == '0);

  assign cap_word.last = m_src_last;
  assign cap_word.data = m_src;

  assign push = ((state_q == StRun) || (state_q == StDrain)) && (occ != 2'd0) &&
                !m_dst_full && (!push_q || !m_dst_almost_full) && !m_reset;

  // Counting the same-cycle push as freeing a slot is what sustains one word per cycle.
  assign occ_eff   = {1'b0, occ} + {2'b0, pop_q} - {2'b0, push};
  assign occ_after = {1'b0, occ} + {2'b0, cap} - {2'b0, push};

  assign pop = (state_q == StRun) && !eol_q && !early_last && !m_src_empty &&
               (rd_left_q != '0) && (occ_eff < BufCap) &&
               (!pop_q || !m_src_almost_empty) && !m_reset;

  m_copy_buf u_buf (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .flush_i (m_reset),
    .wr_i    (cap),
    .wdata_i (cap_word),
    .rd_i    (push),
    .rdata_o (head),
    .occ_o   (occ)
  );

  always_comb begin
    state_d   = state_q;
    rd_left_d = rd_left_q - CntW'(pop);
    wr_left_d = wr_left_q - CntW'(push);
    eol_d     = eol_q | early_last;
    err_d     = err_q | early_last | miss_last;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rd_left_d = words;
          wr_left_d = words;
          eol_d     = 1'b0;
          err_d     = 1'b0;
          state_d   = (words == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (early_last || (rd_left_q == '0)) state_d = StDrain;
      end
      StDrain: begin
        if (occ_after == 3'd0) state_d = StDone;
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (m_reset) begin
      state_d   = StIdle;
      rd_left_d = '0;
      wr_left_d = '0;
      eol_d     = 1'b0;
      err_d     = err_q;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      rd_left_q <= '0;
      wr_left_q <= '0;
      pop_q     <= 1'b0;
      push_q    <= 1'b0;
      eol_q     <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_left_q <= rd_left_d;
      wr_left_q <= wr_left_d;
      pop_q     <= pop;
      push_q    <= push;
      eol_q     <= eol_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign m_src_getn = ~pop;
  assign m_dst_putn = ~push;
  assign m_dst      = push ? head.data : '0;
  assign m_dst_last = push & (head.last | (wr_left_q == CntW'(1)));
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_m_copy_seq.sv
// Directed bench for m_copy_seq with behavioural source/destination FIFO models.
module tb_m_copy_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] dc = '0;
  logic        m_reset = 1'b0;
  logic        getn;
  logic [63:0] m_src = '0;
  logic        m_src_last = 1'b0;
  logic        src_ae, src_e;
  logic        putn;
  logic [63:0] m_dst;
  logic        m_dst_last;
  logic        dst_full_r = 1'b0;
  logic        dst_af, dst_f;
  logic        busy, done, err;

  always #5 clk = ~clk;

  m_copy_seq dut (
    .wb_clk_i           (clk),
    .wb_rst_i           (rst),
    .start              (start),
    .dc                 (dc),
    .m_reset            (m_reset),
    .m_src_getn         (getn),
    .m_src              (m_src),
    .m_src_last         (m_src_last),
    .m_src_almost_empty (src_ae),
    .m_src_empty        (src_e),
    .m_dst_putn         (putn),
    .m_dst              (m_dst),
    .m_dst_last         (m_dst_last),
    .m_dst_almost_full  (dst_af),
    .m_dst_full         (dst_f),
    .busy               (busy),
    .done               (done),
    .err                (err)
  );

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int drive_cyc = 0;

  logic [63:0] src_mem [64];
  logic        src_lmem [64];
  int          src_wr = 0;
  int          src_rd = 0;
  bit          src_flush = 1'b0;

  logic [63:0] dst_mem [128];
  logic        dst_lmem [128];
  int push_n = 0, pop_n = 0, done_n = 0, done_cyc = 0, last_pop_cyc = 0;
  int src_uf = 0, dst_of = 0;

  bit          pop_s = 0, push_s = 0, done_s = 0, empty_s = 0, full_s = 0;
  logic [63:0] dst_s = '0;
  logic        last_s = 1'b0;

  assign src_e  = (src_wr == src_rd);
  assign src_ae = ((src_wr - src_rd) <= 1);
  assign dst_f  = dst_full_r;
  assign dst_af = dst_full_r;

  // Strobes are sampled mid-cycle; the transfer they request happens at the next rising edge.
  always @(negedge clk) begin
    pop_s   = !getn;
    push_s  = !putn;
    done_s  = done;
    empty_s = src_e;
    full_s  = dst_f;
    dst_s   = m_dst;
    last_s  = m_dst_last;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (src_flush) begin
      src_rd <= src_wr;
    end else if (pop_s) begin
      m_src        <= src_mem[src_rd % 64];
      m_src_last   <= src_lmem[src_rd % 64];
      src_rd       <= src_rd + 1;
      pop_n        <= pop_n + 1;
      last_pop_cyc <= cyc;
      if (empty_s) src_uf <= src_uf + 1;
    end
    if (push_s) begin
      dst_mem[push_n % 128]  <= dst_s;
      dst_lmem[push_n % 128] <= last_s;
      push_n                 <= push_n + 1;
      if (full_s) dst_of <= dst_of + 1;
    end
    if (done_s) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_src(input logic [63:0] d, input logic l);
    src_mem[src_wr % 64]  = d;
    src_lmem[src_wr % 64] = l;
    src_wr                = src_wr + 1;
  endtask

  task automatic flush_src();
    src_flush = 1'b1;
    tick();
    src_flush = 1'b0;
  endtask

  task automatic do_start(input logic [23:0] v);
    start     = 1'b1;
    dc        = v;
    drive_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (done_n > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (getn !== 1'b1) begin nfail++; $display("FAIL rst_getn: got %b want 1", getn); end
    nvec++; if (putn !== 1'b1) begin nfail++; $display("FAIL rst_putn: got %b want 1", putn); end
    nvec++; if (m_dst !== 64'h0) begin nfail++; $display("FAIL rst_dst: got %h want 0", m_dst); end
    nvec++; if (m_dst_last !== 1'b0) begin nfail++; $display("FAIL rst_last: got %b want 0", m_dst_last); end
    nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst_busy: got %b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nfail++; $display("FAIL rst_done: got %b want 0", done); end
    nvec++; if (err !== 1'b0) begin nfail++; $display("FAIL rst_err: got %b want 0", err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_copy();
    int pb = push_n, qb = pop_n, db = done_n;
    bit ok;
    for (int i = 0; i < 8; i++) push_src(64'h1000 + 64'(i), (i == 7));
    do_start(24'd64);
    wait_done(db, 60, ok);
    nvec++; if (ok !== 1'b1) begin nfail++; $display("FAIL t1_done: got %b want 1", ok); end
    nvec++; if (push_n - pb !== 8) begin nfail++; $display("FAIL t1_pushes: got %0d want 8", push_n - pb); end
    nvec++; if (pop_n - qb !== 8) begin nfail++; $display("FAIL t1_pops: got %0d want 8", pop_n - qb); end
    for (int i = 0; i < 8; i++) begin
      nvec++;
      if ({dst_lmem[(pb + i) % 128], dst_mem[(pb + i) % 128]} !== {(i == 7), 64'h1000 + 64'(i)}) begin
        nfail++;
        $display("FAIL t1_word%0d: got %b/%h want %b/%h", i, dst_lmem[(pb + i) % 128],
                 dst_mem[(pb + i) % 128], (i == 7), 64'h1000 + 64'(i));
      end
    end
    nvec++; if (done_cyc - last_pop_cyc > 4) begin nfail++; $display("FAIL t1_latency: got %0d want <=4", done_cyc - last_pop_cyc); end
    nvec++; if (err !== 1'b0) begin nfail++; $display("FAIL t1_err: got %b want 0", err); end
    nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL t1_busy: got %b want 0", busy); end
  endtask

  task automatic test_zero_count();
    int pb = push_n, qb = pop_n, db = done_n;
    bit ok;
    do_start(24'd0);
    nvec++; if (busy !== 1'b1) begin nfail++; $display("FAIL t2_busy_hi: got %b want 1", busy); end
    wait_done(db, 10, ok);
    nvec++; if (ok !== 1'b1) begin nfail++; $display("FAIL t2_done: got %b want 1", ok); end
    nvec++; if (done_cyc !== drive_cyc + 2) begin nfail++; $display("FAIL t2_done_cyc: got %0d want %0d", done_cyc, drive_cyc + 2); end
    nvec++; if ((push_n - pb) + (pop_n - qb) !== 0) begin nfail++; $display("FAIL t2_strobes: got %0d want 0", (push_n - pb) + (pop_n - qb)); end
    nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL t2_busy_lo: got %b want 0", busy); end
  endtask

  task automatic test_src_stall();
    int pb = push_n, qb = pop_n, db = done_n, ub = src_uf;
    bit ok;
    push_src(64'h3000, 1'b0);
    do_start(24'd20);
    for (int i = 0; i < 20; i++) begin
      if (pop_n > qb) break;
      tick();
    end
    repeat (5) tick();
    nvec++; if (pop_n - qb !== 1) begin nfail++; $display("FAIL t3_paused_pops: got %0d want 1", pop_n - qb); end
    push_src(64'h3001, 1'b0);
    push_src(64'h3002, 1'b1);
    wait_done(db, 40, ok);
    nvec++; if (ok !== 1'b1) begin nfail++; $display("FAIL t3_done: got %b want 1", ok); end
    nvec++; if (push_n - pb !== 3) begin nfail++; $display("FAIL t3_pushes: got %0d want 3", push_n - pb); end
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if ({dst_lmem[(pb + i) % 128], dst_mem[(pb + i) % 128]} !== {(i == 2), 64'h3000 + 64'(i)}) begin
        nfail++;
        $display("FAIL t3_word%0d: got %b/%h want %b/%h", i, dst_lmem[(pb + i) % 128],
                 dst_mem[(pb + i) % 128], (i == 2), 64'h3000 + 64'(i));
      end
    end
    nvec++; if (src_uf !== ub) begin nfail++; $display("FAIL t3_pop_empty: got %0d want %0d", src_uf, ub); end
    nvec++; if (err !== 1'b0) begin nfail++; $display("FAIL t3_err: got %b want 0", err); end
  endtask

  task automatic test_dst_full();
    int pb = push_n, qb = pop_n, db = done_n, ob = dst_of;
    bit ok;
    for (int i = 0; i < 4; i++) push_src(64'h4000 + 64'(i), (i == 3));
    do_start(24'd32);
    for (int i = 0; i < 20; i++) begin
      if (pop_n > qb) break;
      tick();
    end
    dst_full_r = 1'b1;
    repeat (10) tick();
    nvec++; if (pop_n - qb !== 2) begin nfail++; $display("FAIL t4_buf_cap: got %0d want 2", pop_n - qb); end
    nvec++; if (push_n - pb !== 0) begin nfail++; $display("FAIL t4_held: got %0d want 0", push_n - pb); end
    dst_full_r = 1'b0;
    wait_done(db, 40, ok);
    nvec++; if (ok !== 1'b1) begin nfail++; $display("FAIL t4_done: got %b want 1", ok); end
    nvec++; if (dst_of !== ob) begin nfail++; $display("FAIL t4_push_full: got %0d want %0d", dst_of, ob); end
    nvec++; if (push_n - pb !== 4) begin nfail++; $display("FAIL t4_pushes: got %0d want 4", push_n - pb); end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if ({dst_lmem[(pb + i) % 128], dst_mem[(pb + i) % 128]} !== {(i == 3), 64'h4000 + 64'(i)}) begin
        nfail++;
        $display("FAIL t4_word%0d: got %b/%h want %b/%h", i, dst_lmem[(pb + i) % 128],
                 dst_mem[(pb + i) % 128], (i == 3), 64'h4000 + 64'(i));
      end
    end
  endtask

  task automatic test_early_last();
    int pb = push_n, qb = pop_n, db = done_n;
    bit ok;
    for (int i = 0; i < 10; i++) push_src(64'h5000 + 64'(i), (i == 5));
    do_start(24'd80);
    wait_done(db, 60, ok);
    nvec++; if (ok !== 1'b1) begin nfail++; $display("FAIL t5_done: got %b want 1", ok); end
    nvec++; if (err !== 1'b1) begin nfail++; $display("FAIL t5_err: got %b want 1", err); end
    nvec++; if (push_n - pb !== 6) begin nfail++; $display("FAIL t5_pushes: got %0d want 6", push_n - pb); end
    nvec++; if (pop_n - qb !== 6) begin nfail++; $display("FAIL t5_pops: got %0d want 6", pop_n - qb); end
    for (int i = 0; i < 6; i++) begin
      nvec++;
      if ({dst_lmem[(pb + i) % 128], dst_mem[(pb + i) % 128]} !== {(i == 5), 64'h5000 + 64'(i)}) begin
        nfail++;
        $display("FAIL t5_word%0d: got %b/%h want %b/%h", i, dst_lmem[(pb + i) % 128],
                 dst_mem[(pb + i) % 128], (i == 5), 64'h5000 + 64'(i));
      end
    end
    flush_src();
    pb = push_n;
    db = done_n;
    push_src(64'h5100, 1'b1);
    do_start(24'd8);
    nvec++; if (err !== 1'b0) begin nfail++; $display("FAIL t5_err_clr: got %b want 0", err); end
    wait_done(db, 20, ok);
    nvec++; if (ok !== 1'b1) begin nfail++; $display("FAIL t5_redo_done: got %b want 1", ok); end
    nvec++;
    if ({dst_lmem[pb % 128], dst_mem[pb % 128]} !== {1'b1, 64'h5100}) begin
      nfail++;
      $display("FAIL t5_redo_word: got %b/%h want 1/5100", dst_lmem[pb % 128], dst_mem[pb % 128]);
    end
  endtask

  task automatic test_abort();
    int pb = push_n, db = done_n, hold;
    bit ok;
    for (int i = 0; i < 8; i++) push_src(64'h6000 + 64'(i), (i == 7));
    do_start(24'd64);
    for (int i = 0; i < 30; i++) begin
      if (push_n - pb >= 3) break;
      tick();
    end
    m_reset = 1'b1;
    tick();
    m_reset = 1'b0;
    hold = push_n;
    nvec++; if (getn !== 1'b1) begin nfail++; $display("FAIL t6_getn: got %b want 1", getn); end
    nvec++; if (putn !== 1'b1) begin nfail++; $display("FAIL t6_putn: got %b want 1", putn); end
    nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL t6_idle: got %b want 0", busy); end
    repeat (6) tick();
    nvec++; if (done_n !== db) begin nfail++; $display("FAIL t6_no_done: got %0d want %0d", done_n, db); end
    nvec++; if (push_n !== hold) begin nfail++; $display("FAIL t6_no_push: got %0d want %0d", push_n, hold); end
    flush_src();
    pb = push_n;
    push_src(64'h6100, 1'b1);
    do_start(24'd8);
    wait_done(db, 20, ok);
    nvec++; if (ok !== 1'b1) begin nfail++; $display("FAIL t6_redo_done: got %b want 1", ok); end
    nvec++; if (push_n - pb !== 1) begin nfail++; $display("FAIL t6_redo_pushes: got %0d want 1", push_n - pb); end
    nvec++;
    if ({dst_lmem[pb % 128], dst_mem[pb % 128]} !== {1'b1, 64'h6100}) begin
      nfail++;
      $display("FAIL t6_redo_word: got %b/%h want 1/6100", dst_lmem[pb % 128], dst_mem[pb % 128]);
    end
    nvec++; if (err !== 1'b0) begin nfail++; $display("FAIL t6_err: got %b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_full_copy();
    test_zero_count();
    test_src_stall();
    test_dst_full();
    test_early_last();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
